// File: rtl/dma_cmd_sequencer_if.sv
// Command/engine bundle for dma_cmd_sequencer.
//   cmd_*  : copy-command handshake into the sequencer FIFO
//   dma_*  : chunk start pulse, chunk descriptor and completion pulse
// Modports:
//   master : the sequencer view (accepts commands, drives the engine)
//   slave  : the opposite side (command source plus copy engine)
interface dma_cmd_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_src;
  logic [ADDR_W-1:0] cmd_dst;
  logic [LEN_W-1:0]  cmd_len;

  logic              dma_start;
  logic [ADDR_W-1:0] dma_src;
  logic [ADDR_W-1:0] dma_dst;
  logic [LEN_W-1:0]  dma_len;
  logic              dma_done;

  modport master (
    input  cmd_valid, cmd_src, cmd_dst, cmd_len,
    output cmd_ready,
    output dma_start, dma_src, dma_dst, dma_len,
    input  dma_done
  );

  modport slave (
    output cmd_valid, cmd_src, cmd_dst, cmd_len,
    input  cmd_ready,
    input  dma_start, dma_src, dma_dst, dma_len,
    output dma_done
  );
endinterface

// File: rtl/dma_cmd_sequencer.sv
// dma_cmd_sequencer: front end of the DMA copy engine.
// Queues copy commands (src, dst, len) in a FIFO_DEPTH-entry FIFO, splits each
// into chunks of at most MAX_CHUNK bytes and hands them to the engine one at a
// time: one-cycle dma_start per chunk, then wait for the engine's dma_done.
//
// Ports:
//   clk          single rising-edge clock
//   areset       synchronous active-high reset (shared with the engine)
//   bus          dma_cmd_sequencer_if.master: cmd_* handshake and dma_* engine side
//   busy         sequencer active or commands queued
//   cmds_done    retired-command counter (wraps at 2^16)
//   zlen_seen    sticky, a zero-length command was retired
//   err_timeout  sticky watchdog flag
//
// Optional feature, macro DMA_CMD_TIMEOUT_EN: a watchdog that abandons a chunk
// whose dma_done has not arrived after TIMEOUT_CYCLES cycles in WAIT. Without
// the macro err_timeout is tied low and WAIT lasts until dma_done.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no command active; pops the FIFO head when one is queued
// ISSUE  | dma_start high for this single cycle, descriptor on dma_*
// WAIT   | chunk in flight; descriptor held until dma_done
module dma_cmd_sequencer #(
  parameter int ADDR_W         = 32,
  parameter int LEN_W          = 16,
  parameter int MAX_CHUNK      = 4096,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                areset,
  dma_cmd_sequencer_if.master bus,
  output logic                busy,
  output logic [15:0]         cmds_done,
  output logic                zlen_seen,
  output logic                err_timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [LEN_W-1:0] CHUNK = LEN_W'(MAX_CHUNK);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  if (MAX_CHUNK <= 0 || 64'(MAX_CHUNK) >= (64'd1 << LEN_W)) begin : g_bad_chunk
    $error("dma_cmd_sequencer: MAX_CHUNK must be in 1 .. 2^LEN_W-1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("dma_cmd_sequencer: FIFO_DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("dma_cmd_sequencer: TIMEOUT_CYCLES must be >= 1");
  end

  logic [ADDR_W-1:0] fifo_src [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_dst [FIFO_DEPTH];
  logic [LEN_W-1:0]  fifo_len [FIFO_DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;

  logic [1:0]        state;
  logic [LEN_W-1:0]  rem;

  logic [ADDR_W-1:0] head_src;
  logic [ADDR_W-1:0] head_dst;
  logic [LEN_W-1:0]  head_len;
  logic [LEN_W-1:0]  rem_next;
  logic [ADDR_W-1:0] src_next;
  logic [ADDR_W-1:0] dst_next;
  logic              wd_expire;

  function automatic logic [LEN_W-1:0] chunk_of(input logic [LEN_W-1:0] n);
    return (n > CHUNK) ? CHUNK : n;
  endfunction

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Derived only from registered pointers, so a pop cannot raise it in the
  // same cycle; the freed slot is visible one cycle later.
  assign bus.cmd_ready = !full && !areset;
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign pop           = (state == ST_IDLE) && !empty;
  assign busy          = (state != ST_IDLE) || !empty;

  assign head_src = fifo_src[rd_ptr[AW-1:0]];
  assign head_dst = fifo_dst[rd_ptr[AW-1:0]];
  assign head_len = fifo_len[rd_ptr[AW-1:0]];

  // dma_src/dma_dst double as the working addresses of the active command.
  assign rem_next = rem - bus.dma_len;
  assign src_next = bus.dma_src + ADDR_W'(bus.dma_len);
  assign dst_next = bus.dma_dst + ADDR_W'(bus.dma_len);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_src[wr_ptr[AW-1:0]] <= bus.cmd_src;
      fifo_dst[wr_ptr[AW-1:0]] <= bus.cmd_dst;
      fifo_len[wr_ptr[AW-1:0]] <= bus.cmd_len;
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      state         <= ST_IDLE;
      rem           <= '0;
      bus.dma_start <= 1'b0;
      bus.dma_src   <= '0;
      bus.dma_dst   <= '0;
      bus.dma_len   <= '0;
      cmds_done     <= '0;
      zlen_seen     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      bus.dma_start <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (pop) begin
            if (head_len == '0) begin
              // Nothing to move: retire on the spot, engine never sees it.
              cmds_done <= cmds_done + 1'b1;
              zlen_seen <= 1'b1;
            end else begin
              rem           <= head_len;
              bus.dma_src   <= head_src;
              bus.dma_dst   <= head_dst;
              bus.dma_len   <= chunk_of(head_len);
              bus.dma_start <= 1'b1;
              state         <= ST_ISSUE;
            end
          end
        end

        // dma_done is deliberately ignored here.
        ST_ISSUE: state <= ST_WAIT;

        ST_WAIT: begin
          if (bus.dma_done) begin
            rem <= rem_next;
            if (rem_next == '0) begin
              cmds_done <= cmds_done + 1'b1;
              state     <= ST_IDLE;
            end else begin
              bus.dma_src   <= src_next;
              bus.dma_dst   <= dst_next;
              bus.dma_len   <= chunk_of(rem_next);
              bus.dma_start <= 1'b1;
              state         <= ST_ISSUE;
            end
          end else if (wd_expire) begin
            // Abandon the command without counting it.
            rem   <= '0;
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DMA_CMD_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  // Down-counter loaded during ISSUE; reaching zero on a WAIT cycle without
  // dma_done marks the TIMEOUT_CYCLES-th such cycle.
  logic [WD_W-1:0] wd_cnt;

  assign wd_expire = (state == ST_WAIT) && !bus.dma_done && (wd_cnt == '0);

  always_ff @(posedge clk) begin
    if (areset) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == ST_ISSUE) begin
        wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
      end else if (state == ST_WAIT && !bus.dma_done && wd_cnt != '0) begin
        wd_cnt <= wd_cnt - 1'b1;
      end
      if (wd_expire) err_timeout <= 1'b1;
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: doc/dma_cmd_sequencer.md
Name: dma_cmd_sequencer

Overview:
- Upstream command stage for the DMA copy engine used by the persistent-memory copy/logging datapath.
- Buffers copy commands (src, dst, len) in a small FIFO.
- Splits each command into chunks of at most MAX_CHUNK bytes.
- Drives the engine's one-cycle start pulse per chunk and waits for its done pulse before issuing the next chunk.

Parameters:
ADDR_W, 32, byte-address width of src/dst
LEN_W, 16, command length width in bytes
MAX_CHUNK, 4096, largest length issued in one engine transfer (must be >0 and <2^LEN_W)
FIFO_DEPTH, 4, command FIFO entries (power of two)
TIMEOUT_CYCLES, 1024, watchdog limit; used only with DMA_CMD_TIMEOUT_EN

Ports:
clk  in  1  single clock, all logic on rising edge
areset  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO not full; equals !full, with no combinational path from the pop side
cmd_src  in  ADDR_W  source byte address
cmd_dst  in  ADDR_W  destination byte address
cmd_len  in  LEN_W  length in bytes
dma_start  out  1  one-cycle start pulse to the engine
dma_src  out  ADDR_W  chunk source address
dma_dst  out  ADDR_W  chunk destination address
dma_len  out  LEN_W  chunk length
dma_done  in  1  one-cycle completion pulse from the engine
busy  out  1  high when state!=IDLE or FIFO not empty
cmds_done  out  16  retired-command counter, wraps at 2^16
zlen_seen  out  1  sticky: a zero-length command was retired
err_timeout  out  1  sticky watchdog flag; tied 0 without the macro

Behaviour:
- Reset (areset=1 at an edge) clears:
  - FIFO pointers, so FIFO is empty;
  - state to IDLE;
  - dma_start, dma_src, dma_dst, dma_len, cmds_done, zlen_seen and err_timeout, all to 0.
- During reset, cmd_ready=0.
- Reset mid-transfer abandons the command; the engine shares areset and is reset with it.
- Push: a command is written when cmd_valid && cmd_ready at an edge.
  - cmd_valid while full is ignored; the source holds the command.
- FSM has states IDLE, ISSUE, WAIT.
- IDLE:
  - If the FIFO is non-empty, pop the head into working registers: cur_src, cur_dst, rem=len.
  - If len==0: retire immediately (cmds_done+1, zlen_seen<=1), stay in IDLE, no dma_start.
  - Otherwise go to ISSUE.
- ISSUE (exactly one cycle):
  - dma_start=1.
  - dma_src=cur_src, dma_dst=cur_dst, dma_len=min(rem, MAX_CHUNK).
  - Go to WAIT.
- WAIT:
  - dma_src/dst/len stay stable until dma_done.
  - On dma_done: rem-=dma_len, cur_src+=dma_len, cur_dst+=dma_len.
  - Address adds wrap modulo 2^ADDR_W.
  - If the new rem==0: cmds_done+1, go to IDLE. Otherwise go to ISSUE.
- dma_done in any state other than WAIT is ignored, including the ISSUE cycle itself.
- Latency: with the FIFO empty and state IDLE, a command accepted at edge T gives dma_start high in cycle T+2 (pop in T+1).
- Between chunks: dma_done at edge D gives the next dma_start in cycle D+1.
- Capacity: FIFO_DEPTH queued commands plus 1 in the working registers.
- Push and pop in the same cycle are both allowed; occupancy is unchanged.
- The IDLE pop can free a slot while the FIFO is full, but cmd_ready rises only in the following cycle.

Optional Feature:
- Macro: DMA_CMD_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to WAIT and counts each WAIT cycle without dma_done.
  - On reaching TIMEOUT_CYCLES: err_timeout<=1 (sticky until reset), the current command is dropped and not counted, state goes to IDLE.
  - A dma_done arriving later is ignored.
- Not defined: no counter logic, err_timeout tied 0, WAIT lasts indefinitely.

Test Plan:
- Reset, then cmd src=0x1000 dst=0x8000 len=100; bench returns dma_done 5 cycles after start -> one dma_start in cycle T+2 with 0x1000/0x8000/100; cmds_done=1; busy falls the cycle after done.
- len=10000, MAX_CHUNK=4096 -> three starts:
  - (0x1000, 0x8000, 4096)
  - (0x2000, 0x9000, 4096)
  - (0x3000, 0xA000, 1808)
  - then cmds_done=1.
- Hold dma_done low and offer 7 commands -> 5 accepted (1 active + 4 queued); cmd_ready=0 from then on. Release dma_done -> cmd_ready=1 one cycle after the next pop; all retire in order; cmds_done=5 then 7.
- Zero-length cmd followed by len=8 -> no start for the first; zlen_seen=1; cmds_done=2 after the second completes.
- src=0xFFFFF000 len=8192 -> second chunk src=0x00000000 (wrap).
- Assert areset during WAIT -> next cycle: state IDLE, FIFO empty, dma_start=0, cmds_done=0. With DMA_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16, withhold dma_done -> err_timeout=1 after 16 WAIT cycles and the next queued command issues.
